// File: rtl/sti_binarize_pack.sv
// sti_binarize_pack: thresholds a raster-order grayscale stream to 1 bit per
// pixel, zeroes the one-pixel image border, packs 16 pixels per word MSB-first
// and writes every word of the binary image memory exactly once per frame.
module sti_binarize_pack #(
    parameter int          IMG_W        = 128,
    parameter int          IMG_H        = 128,
    parameter logic [7:0]  THRESH       = 8'd128,
    parameter bit          FORCE_BORDER = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    input  logic        pix_last,
    output logic        pix_ready,
    output logic        sti_we,
    output logic [9:0]  sti_waddr,
    output logic [15:0] sti_wdata,
    output logic        busy,
    output logic        frame_done,
    output logic [14:0] fg_count,
    output logic        err_frame
);

    localparam int N     = IMG_W * IMG_H;
    localparam int WORDS = N / 16;
    localparam int IDX_W = $clog2(N);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    typedef enum logic [2:0] {IDLE, RUN, PAD, FLUSH, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [15:0]      word_p0;
    logic [9:0]       pad_addr;

    logic             xfer;
    logic             border;
    logic             pix_bit;
    logic             last_idx;
    logic             grp_end;
    logic [9:0]       cur_addr;
    logic [15:0]      word_next;

    // Number of set bits in a packed word.
    function automatic logic [4:0] popcount16(input logic [15:0] w);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(w[i]);
        end
        return cnt;
    endfunction

    // Foreground counter add that sticks at the counter's maximum.
    function automatic logic [14:0] sat_add(input logic [14:0] a, input logic [4:0] b);
        logic [15:0] s;
        s = {1'b0, a} + 16'(b);
        return s[15] ? '1 : s[14:0];
    endfunction

    // Stream is ready purely as a decode of the state register.
    assign pix_ready = (state == RUN);

    // Per-pixel decision, group bookkeeping and the word being assembled.
    always_comb begin
        xfer      = pix_valid && (state == RUN);
        border    = (row == '0) || (row == ROW_W'(IMG_H - 1)) ||
                    (col == '0) || (col == COL_W'(IMG_W - 1));
        pix_bit   = (pix_data >= THRESH) && !(FORCE_BORDER && border);
        last_idx  = (idx == IDX_W'(N - 1));
        grp_end   = (idx[3:0] == 4'hF);
        cur_addr  = 10'(idx >> 4);
        // The first pixel of a group starts from a clean word so that a
        // truncated group is automatically zero-padded in its low bits.
        word_next = ((idx[3:0] == 4'h0) ? 16'h0000 : word_p0) |
                    (16'(pix_bit) << (4'd15 - idx[3:0]));
    end

    // Frame control FSM with registered write port and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            word_p0    <= '0;
            pad_addr   <= '0;
            sti_we     <= 1'b0;
            sti_waddr  <= '0;
            sti_wdata  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            fg_count   <= '0;
            err_frame  <= 1'b0;
        end else begin
            sti_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        idx        <= '0;
                        row        <= '0;
                        col        <= '0;
                        word_p0    <= '0;
                        fg_count   <= '0;
                        err_frame  <= 1'b0;
                        frame_done <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        word_p0 <= word_next;
                        idx     <= idx + 1'b1;
                        if (col == COL_W'(IMG_W - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        // A word retires at a group boundary or when the frame
                        // is cut short; it appears on the port next cycle.
                        if (grp_end || last_idx || pix_last) begin
                            sti_we    <= 1'b1;
                            sti_wdata <= word_next;
                            sti_waddr <= cur_addr;
                            fg_count  <= sat_add(fg_count, popcount16(word_next));
                        end
                        if (last_idx) begin
                            state <= FLUSH;
                            if (!pix_last) begin
                                err_frame <= 1'b1;
                            end
                        end else if (pix_last) begin
                            err_frame <= 1'b1;
                            if (cur_addr == 10'(WORDS - 1)) begin
                                state <= FLUSH;
                            end else begin
                                state    <= PAD;
                                pad_addr <= cur_addr + 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    // Fill the rest of the image so every address is written.
                    sti_we    <= 1'b1;
                    sti_wdata <= 16'h0000;
                    sti_waddr <= pad_addr;
                    if (pad_addr == 10'(WORDS - 1)) begin
                        state <= FLUSH;
                    end else begin
                        pad_addr <= pad_addr + 1'b1;
                    end
                end
                FLUSH: begin
                    state      <= DONE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sti_binarize_pack.sv
// Testbench for sti_binarize_pack: directed frames with random pixel content,
// checked against an image model computed from row/column arithmetic.
module tb_sti_binarize_pack;

    localparam int         IMG_W  = 128;
    localparam int         IMG_H  = 128;
    localparam int         N      = IMG_W * IMG_H;
    localparam int         WORDS  = N / 16;
    localparam logic [7:0] THRESH = 8'd128;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_last = 1'b0;
    logic        pix_ready;
    logic        sti_we;
    logic [9:0]  sti_waddr;
    logic [15:0] sti_wdata;
    logic        busy;
    logic        frame_done;
    logic [14:0] fg_count;
    logic        err_frame;

    sti_binarize_pack #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .THRESH(THRESH), .FORCE_BORDER(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
        .pix_ready(pix_ready), .sti_we(sti_we), .sti_waddr(sti_waddr),
        .sti_wdata(sti_wdata), .busy(busy), .frame_done(frame_done),
        .fg_count(fg_count), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int          ncmp = 0;
    int          nfail = 0;
    logic [7:0]  pix [N];
    logic [15:0] mem [WORDS];
    logic [15:0] exp_mem [WORDS];
    logic [15:0] saved_mem [WORDS];
    int          exp_fg;
    int          saved_fg;
    int          wr_count = 0;
    int          exp_addr = 0;
    int          xfers = 0;
    bit          chk_spacing = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Write-port monitor: ordering, spacing and capture of the memory image.
    always @(negedge clk) begin
        if (reset) begin
            if (sti_we) begin
                check("waddr_order", 32'(sti_waddr), exp_addr);
                if (chk_spacing) check("we_spacing", xfers, 16);
                mem[sti_waddr] = sti_wdata;
                wr_count++;
                exp_addr++;
                xfers = 0;
            end
            if (pix_valid && pix_ready) xfers++;
        end else begin
            xfers = 0;
        end
    end

    // Reference image: thresholded pixels, border zeroed, nothing past last_at.
    task automatic build_model(input int last_at);
        exp_fg = 0;
        for (int w = 0; w < WORDS; w++) begin
            logic [15:0] word;
            word = 16'h0000;
            for (int k = 0; k < 16; k++) begin
                int i, r, c;
                bit b;
                i = w * 16 + k;
                r = i / IMG_W;
                c = i % IMG_W;
                b = (i <= last_at) && (pix[i] >= THRESH) &&
                    !(r == 0 || r == IMG_H - 1 || c == 0 || c == IMG_W - 1);
                word[15 - k] = b;
                exp_fg += int'(b);
            end
            exp_mem[w] = word;
        end
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_we"}, 32'(sti_we), 0);
        check({tag, "_waddr"}, 32'(sti_waddr), 0);
        check({tag, "_wdata"}, 32'(sti_wdata), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_fg"}, 32'(fg_count), 0);
        check({tag, "_err"}, 32'(err_frame), 0);
        check({tag, "_ready"}, 32'(pix_ready), 0);
    endtask

    task automatic do_start();
        for (int w = 0; w < WORDS; w++) mem[w] = 'x;
        exp_addr = 0;
        wr_count = 0;
        xfers = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_done_clr", 32'(frame_done), 0);
        check("start_fg_clr", 32'(fg_count), 0);
        check("start_err_clr", 32'(err_frame), 0);
        check("start_ready", 32'(pix_ready), 1);
    endtask

    // Drive pixels 0..stop_at; pix_last on last_pos (-1 = never).
    task automatic stream(input int last_pos, input int stop_at, input int gap_pct,
                          input int start_at, input int reset_at);
        int i = 0;
        int stall = 0;
        bit taken;
        while (i <= stop_at) begin
            if (i == reset_at) begin
                pix_valid = 1'b0;
                reset = 1'b0;
                #1;
                outputs_zero("midreset");
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                check("postreset_ready", 32'(pix_ready), 0);
                return;
            end
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                pix_valid = 1'b0;
                pix_data  = 8'($urandom);
                pix_last  = 1'($urandom);
            end else begin
                pix_valid = 1'b1;
                pix_data  = pix[i];
                pix_last  = (i == last_pos);
            end
            start = (i == start_at);
            taken = pix_valid && pix_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (taken) begin
                i++;
                stall = 0;
            end else if (++stall > 100) begin
                check("stream_stall", 0, 1);
                break;
            end
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input bit exp_err);
        int n = 0;
        while (!frame_done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done"}, 32'(frame_done), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_writes"}, wr_count, WORDS);
        check({tag, "_fg"}, 32'(fg_count), exp_fg);
        check({tag, "_err"}, 32'(err_frame), 32'(exp_err));
        for (int w = 0; w < WORDS; w++)
            check($sformatf("%s_word%0d", tag, w), 32'(mem[w]), 32'(exp_mem[w]));
    endtask

    initial begin
        int wc;
        repeat (3) @(posedge clk);
        #1;
        outputs_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset partway through a frame.
        for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
        chk_spacing = 1'b1;
        do_start();
        stream(N - 1, N - 1, 0, -1, 5000);

        // All-white frame after the reset.
        for (int i = 0; i < N; i++) pix[i] = 8'hFF;
        build_model(N - 1);
        do_start();
        stream(N - 1, N - 1, 0, -1, -1);
        finish_frame("white", 1'b0);
        check("white_w0", 32'(mem[0]), 32'h0000);
        check("white_w8", 32'(mem[8]), 32'h7FFF);
        check("white_w15", 32'(mem[15]), 32'hFFFE);
        for (int w = 1016; w < 1024; w++)
            check($sformatf("white_tail%0d", w), 32'(mem[w]), 32'h0000);
        check("white_fg_const", 32'(fg_count), 15876);

        // Stream activity while DONE is ignored.
        wc = wr_count;
        pix_valid = 1'b1;
        pix_last  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        check("idle_no_write", wr_count, wc);
        check("idle_still_done", 32'(frame_done), 1);

        // Threshold boundary at row 5, col 17; frame cut short at 700.
        chk_spacing = 1'b0;
        for (int i = 0; i < N; i++) pix[i] = 8'h00;
        pix[5 * IMG_W + 17] = THRESH - 8'd1;
        build_model(700);
        do_start();
        stream(700, 700, 0, -1, -1);
        finish_frame("th_lo", 1'b1);
        check("th_lo_w41", 32'(mem[41]), 32'h0000);
        check("th_lo_fg", 32'(fg_count), 0);

        pix[5 * IMG_W + 17] = THRESH;
        build_model(700);
        do_start();
        stream(700, 700, 0, -1, -1);
        finish_frame("th_eq", 1'b1);
        check("th_eq_w41", 32'(mem[41]), 32'h4000);
        check("th_eq_fg", 32'(fg_count), 1);

        // Early pix_last on pixel 100 of an all-white frame.
        for (int i = 0; i < N; i++) pix[i] = 8'hFF;
        build_model(100);
        do_start();
        stream(100, 100, 0, -1, -1);
        finish_frame("early100", 1'b1);
        check("early100_w6", 32'(mem[6]), 32'h0000);
        check("early100_w7", 32'(mem[7]), 32'h0000);

        // Early pix_last mid-row on random content: partial word padding.
        for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
        build_model(1000);
        do_start();
        stream(1000, 1000, 0, -1, -1);
        finish_frame("early1000", 1'b1);

        // Gapped random frame with a stray start mid-stream.
        chk_spacing = 1'b1;
        for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
        build_model(N - 1);
        do_start();
        stream(N - 1, N - 1, 25, 300, -1);
        finish_frame("gapped", 1'b0);
        for (int w = 0; w < WORDS; w++) saved_mem[w] = mem[w];
        saved_fg = int'(fg_count);

        // Same pixels without gaps and without pix_last.
        do_start();
        stream(-1, N - 1, 0, -1, -1);
        finish_frame("nolast", 1'b1);
        check("nolast_fg_same", 32'(fg_count), saved_fg);
        for (int w = 0; w < WORDS; w += 37)
            check($sformatf("nolast_same%0d", w), 32'(mem[w]), 32'(saved_mem[w]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/sti_binarize_pack.md
Name: sti_binarize_pack

Overview:
Upstream stage of the distance-transform engine. Accepts a 128x128 8-bit grayscale pixel stream in raster order and thresholds each pixel to 1 bit. Forces the one-pixel image border to 0, because the DT 3x3 window does not guard edges. Packs 16 pixels per word, MSB-first, and writes the 1024x16 binary image memory that the DT block later reads via sti_addr/sti_di.

Parameters:
IMG_W, 128, image width in pixels; must be a multiple of 16
IMG_H, 128, image height in pixels
THRESH, 8'd128, pixel is foreground when pix_data >= THRESH
FORCE_BORDER, 1, 1 = row 0, row IMG_H-1, col 0 and col IMG_W-1 are forced to 0

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a frame when idle
pix_valid  input  1  pixel stream valid
pix_data  input  8  grayscale pixel
pix_last  input  1  marks final pixel of the frame, qualified by pix_valid
pix_ready  output  1  stream ready; high only in RUN
sti_we  output  1  binary image memory write enable
sti_waddr  output  10  word address (IMG_W*IMG_H/16 words)
sti_wdata  output  16  packed word; bit 15 = first pixel of the group
busy  output  1  high from start acceptance until frame_done rises
frame_done  output  1  level; high from frame completion until next accepted start
fg_count  output  15  number of 1 bits written in the current or last frame
err_frame  output  1  sticky per frame; pix_last misplaced or missing

Behaviour:
- Reset values: all outputs 0, state IDLE, pixel counter 0, shift register 0.
- Transfer occurs on a cycle with pix_valid && pix_ready. pix_ready is decoded from the state register only (Moore), never from pix_valid.
- States:
  - IDLE: on start go to RUN, clear fg_count, err_frame, counters and frame_done; set busy.
  - RUN: accept pixels. After the transfer of pixel index N-1 (N = IMG_W*IMG_H), go to FLUSH. After an early pix_last, go to PAD.
  - PAD: write zero words until address N/16-1 has been written, then go to FLUSH.
  - FLUSH: one cycle, so the final write retires. Then go to DONE.
  - DONE: frame_done=1, busy=0. On start, behave as IDLE.
- start is ignored in RUN, PAD and FLUSH.
- Pixel bit = (pix_data >= THRESH) && !(FORCE_BORDER && border). Row and column come from the pixel counter: col = idx % IMG_W, row = idx / IMG_W.
- Bits shift into a 16-bit register MSB-first. The k-th pixel of a group lands at bit 15-k.
- Write timing: sti_we pulses one cycle after the 16th pixel of a group transfers. On that cycle:
  - sti_wdata = the completed word;
  - sti_waddr = pixel index of the group's first pixel / 16;
  - fg_count increments by the popcount of the word, in the same cycle.
- Write latency is 1 clk from the final pixel transfer to sti_we. There is no stall on the write side; one write per 16 transfers at most.
- Early pix_last (index < N-1):
  - err_frame=1;
  - the partial word is zero-padded in the low bits and written at its address on the next cycle;
  - PAD then writes 0x0000 to every remaining address, one per cycle, in ascending order.
- Missing pix_last on index N-1: err_frame=1, and the frame completes normally.
- Every frame writes each address 0..N/16-1 exactly once, in ascending order.
- fg_count saturates at its width maximum; this is unreachable with the defaults.
- Reset mid-frame: all outputs return to reset values immediately. Memory contents are undefined; a new start rewrites the full image.
- pix_valid outside RUN is ignored and no data is consumed.

Test Plan:
- All pixels 0xFF with FORCE_BORDER=1:
  - word 0 = 0x0000 (row 0);
  - word 8 = 0x7FFF (row 1, col 0 forced);
  - word 15 = 0xFFFE (row 1, col 127 forced);
  - words 1016..1023 = 0x0000;
  - fg_count = 126*126 = 15876;
  - err_frame = 0.
- Pixel value = THRESH-1 vs THRESH at row 5, col 17 (word 41, bit 14), all others 0 → bit is 0 for THRESH-1 and 1 for THRESH; fg_count = 0 vs 1.
- pix_valid toggled randomly and gapped → identical memory image and fg_count as the gapless run; sti_we never pulses twice within 16 transfers.
- pix_last on pixel 100 with all pixels 0xFF:
  - word 6 gets bits for pixels 96..100 only = 0xF800, except border bits (none in row 0 are set, so 0x0000);
  - words 7..1023 = 0;
  - err_frame = 1, frame_done = 1.
- start asserted mid-RUN → ignored. reset pulled low at pixel 5000 → all outputs 0. A new start then completes a full frame with 1024 writes.
- Back-to-back frames → frame_done drops on the second start; fg_count and err_frame clear; addresses restart at 0.
